// File: rtl/itu656_encoder_if.sv
// Pixel word handshake between the upstream pixel source and the ITU-R 656 encoder.
// The master drives pix_data and pix_valid; the slave drives pix_ready.
interface itu656_encoder_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/itu656_encoder.sv
// ITU-R 656 transmitter: turns 4:2:2 {Y,C} words into a 525-line byte stream.
// The stream carries EAV/SAV timing codes and blanking fill, one byte per clock.
module itu656_encoder #(
    parameter int BYTES_LINE  = 1716,
    parameter int ACT_BYTES   = 1440,
    parameter int LINES_FRAME = 525,
    parameter int F0_START    = 4,
    parameter int F1_START    = 266,
    parameter int ACT0_FIRST  = 20,
    parameter int ACT0_LAST   = 263,
    parameter int ACT1_FIRST  = 283,
    parameter int ACT1_LAST   = 525
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               enable,
    itu656_encoder_if.slave    pix,
    output logic [7:0]         td_data,
    output logic               td_h,
    output logic               td_v,
    output logic               td_field,
    output logic               sof,
    output logic               underflow
);
    localparam int CW = $clog2(BYTES_LINE);
    localparam int LW = $clog2(LINES_FRAME + 1);

    localparam logic [CW-1:0] C_LAST = CW'(BYTES_LINE - 1);
    localparam logic [CW-1:0] C_EAVE = CW'(4);
    localparam logic [CW-1:0] C_SAV  = CW'(BYTES_LINE - ACT_BYTES - 4);
    localparam logic [CW-1:0] C_ACT  = CW'(BYTES_LINE - ACT_BYTES);
    localparam logic [LW-1:0] L_LAST = LW'(LINES_FRAME);
    localparam logic [LW-1:0] L_F0   = LW'(F0_START);
    localparam logic [LW-1:0] L_F1   = LW'(F1_START);
    localparam logic [LW-1:0] L_A0F  = LW'(ACT0_FIRST);
    localparam logic [LW-1:0] L_A0L  = LW'(ACT0_LAST);
    localparam logic [LW-1:0] L_A1F  = LW'(ACT1_FIRST);
    localparam logic [LW-1:0] L_A1L  = LW'(ACT1_LAST);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_byte_cnt;
    logic [LW-1:0]   r_line;
    logic [7:0]      r_y;
    logic            r_y_ok;

    logic            w_eol;
    logic            w_f;
    logic            w_v;
    logic            w_h;
    logic [7:0]      w_xy;
    logic            w_code;
    logic [1:0]      w_k;
    logic            w_act;
    logic            w_chroma;
    logic            w_under;
    logic [7:0]      w_byte;

    // Reserved codes 00/FF must never appear inside the payload.
    function automatic logic [7:0] f_clip(input logic [7:0] b);
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
        return b;
    endfunction

    assign w_eol = (r_byte_cnt == C_LAST);
    assign w_f   = !(r_line >= L_F0 && r_line < L_F1);
    assign w_v   = !((r_line >= L_A0F && r_line <= L_A0L) ||
                     (r_line >= L_A1F && r_line <= L_A1L));
    assign w_h   = (r_byte_cnt < C_SAV);
    assign w_xy  = {1'b1, w_f, w_v, w_h, w_v ^ w_h, w_f ^ w_h,
                    w_f ^ w_v, w_f ^ w_v ^ w_h};

    assign w_code = (r_byte_cnt < C_EAVE) ||
                    (r_byte_cnt >= C_SAV && r_byte_cnt < C_ACT);
    assign w_k    = w_h ? r_byte_cnt[1:0] : 2'(r_byte_cnt - C_SAV);

    assign w_act    = (r_state == S_RUN) && !w_v && (r_byte_cnt >= C_ACT);
    assign w_chroma = w_act && !r_byte_cnt[0];
    assign w_under  = w_chroma && !pix.pix_valid;

    assign pix.pix_ready = w_chroma;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (enable) w_next = S_RUN;
            S_RUN:  if (w_eol && r_line == L_LAST && !enable) w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_byte_cnt <= '0;
            r_line     <= LW'(1);
        end else if (r_state == S_RUN && w_next == S_RUN) begin
            if (w_eol) begin
                r_byte_cnt <= '0;
                r_line     <= (r_line == L_LAST) ? LW'(1) : r_line + 1'b1;
            end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end else begin
            r_byte_cnt <= '0;
            r_line     <= LW'(1);
        end
    end

    // Luma of the word taken on the chroma slot goes out on the following slot.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_y    <= 8'h00;
            r_y_ok <= 1'b0;
        end else if (w_chroma) begin
            r_y    <= f_clip(pix.pix_data[15:8]);
            r_y_ok <= pix.pix_valid;
        end
    end

    always_comb begin
        w_byte = r_byte_cnt[0] ? 8'h10 : 8'h80;
        if (w_code) begin
            unique case (w_k)
                2'd0:    w_byte = 8'hFF;
                2'd3:    w_byte = w_xy;
                default: w_byte = 8'h00;
            endcase
        end else if (w_act) begin
            if (!r_byte_cnt[0])
                w_byte = pix.pix_valid ? f_clip(pix.pix_data[7:0]) : 8'h80;
            else
                w_byte = r_y_ok ? r_y : 8'h10;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            td_data   <= 8'h10;
            td_h      <= 1'b1;
            td_v      <= 1'b1;
            td_field  <= 1'b1;
            sof       <= 1'b0;
            underflow <= 1'b0;
        end else if (r_state == S_RUN) begin
            td_data   <= w_byte;
            td_h      <= w_h;
            td_v      <= w_v;
            td_field  <= w_f;
            sof       <= (r_byte_cnt == '0) && (r_line == LW'(1));
            underflow <= w_under;
        end else begin
            td_data   <= 8'h10;
            td_h      <= 1'b1;
            td_v      <= 1'b1;
            td_field  <= 1'b1;
            sof       <= 1'b0;
            underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_itu656_encoder.sv
// Bench for itu656_encoder on a shrunken raster (48 bytes x 21 lines).
// A position-based stream model is compared every cycle; literal bytes pin it.
module tb_itu656_encoder;
    localparam int BL    = 48;
    localparam int ACT   = 20;
    localparam int LF    = 21;
    localparam int F0    = 2;
    localparam int F1    = 11;
    localparam int A0F   = 4;
    localparam int A0L   = 9;
    localparam int A1F   = 13;
    localparam int A1L   = 21;
    localparam int SAVP  = BL - ACT - 4;
    localparam int ACTP  = BL - ACT;
    localparam int FRAME = BL * LF;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] td_data;
    logic       td_h, td_v, td_field, sof, underflow;

    itu656_encoder_if pif ();

    itu656_encoder #(
        .BYTES_LINE (BL),  .ACT_BYTES (ACT), .LINES_FRAME (LF),
        .F0_START   (F0),  .F1_START  (F1),
        .ACT0_FIRST (A0F), .ACT0_LAST (A0L),
        .ACT1_FIRST (A1F), .ACT1_LAST (A1L)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .enable    (enable),
        .pix       (pif),
        .td_data   (td_data),
        .td_h      (td_h),
        .td_v      (td_v),
        .td_field  (td_field),
        .sof       (sof),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] clip8(input logic [7:0] b);
        if (b == 8'h00) return 8'h01;
        if (b == 8'hFF) return 8'hFE;
        return b;
    endfunction

    function automatic logic fbit(input int line);
        return !(line >= F0 && line < F1);
    endfunction

    function automatic logic vbit(input int line);
        return !((line >= A0F && line <= A0L) || (line >= A1F && line <= A1L));
    endfunction

    function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic int p(input int line, input int c);
        return (line - 1) * BL + c;
    endfunction

    function automatic logic rdy_at(input int ps);
        if (ps < 0) return 1'b0;
        return !vbit(ps / BL + 1) && (ps % BL) >= ACTP && (ps % BL) % 2 == 0;
    endfunction

    // Model: pos is the raster position about to be emitted, -1 when idle.
    int         pos = -1;
    int         e_pos = -1;
    int         m_line, m_c, m_k;
    logic [7:0] e_data = 8'h10;
    logic       e_h = 1'b1, e_v = 1'b1, e_f = 1'b1, e_sof = 1'b0, e_und = 1'b0;
    logic [7:0] ey = 8'h00;
    bit         ey_ok = 1'b0;

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            pos = -1; e_pos = -1; e_data = 8'h10;
            e_h = 1; e_v = 1; e_f = 1; e_sof = 0; e_und = 0; ey_ok = 0;
        end else if (pos < 0) begin
            e_pos = -1; e_data = 8'h10;
            e_h = 1; e_v = 1; e_f = 1; e_sof = 0; e_und = 0;
            if (enable) pos = 0;
        end else begin
            m_line = pos / BL + 1;
            m_c = pos % BL;
            e_pos = pos;
            e_f = fbit(m_line);
            e_v = vbit(m_line);
            e_h = (m_c < SAVP);
            e_sof = (pos == 0);
            e_und = 0;
            if (m_c < 4 || (m_c >= SAVP && m_c < SAVP + 4)) begin
                m_k = (m_c < 4) ? m_c : m_c - SAVP;
                e_data = (m_k == 0) ? 8'hFF : (m_k == 3) ? xy(e_f, e_v, e_h) : 8'h00;
            end else if (!e_v && m_c >= ACTP) begin
                if (m_c % 2 == 0) begin
                    if (pif.pix_valid) begin
                        e_data = clip8(pif.pix_data[7:0]);
                        ey = clip8(pif.pix_data[15:8]);
                        ey_ok = 1;
                    end else begin
                        e_data = 8'h80;
                        e_und = 1;
                        ey_ok = 0;
                    end
                end else begin
                    e_data = ey_ok ? ey : 8'h10;
                end
            end else begin
                e_data = (m_c % 2) ? 8'h10 : 8'h80;
            end
            if (pos == FRAME - 1 && !enable) pos = -1;
            else pos = (pos + 1) % FRAME;
        end
    end

    logic [7:0] tr_d [FRAME];
    bit         tr_s [FRAME];
    bit         tr_u [FRAME];
    bit         tr_r [FRAME];
    bit         tr_hs [FRAME];
    bit         tr_done = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("td_data", {24'd0, td_data}, {24'd0, e_data});
            chk("td_h", {31'd0, td_h}, {31'd0, e_h});
            chk("td_v", {31'd0, td_v}, {31'd0, e_v});
            chk("td_field", {31'd0, td_field}, {31'd0, e_f});
            chk("sof", {31'd0, sof}, {31'd0, e_sof});
            chk("underflow", {31'd0, underflow}, {31'd0, e_und});
            chk("pix_ready", {31'd0, pif.pix_ready}, {31'd0, rdy_at(pos)});
            if (!tr_done && e_pos >= 0) begin
                tr_d[e_pos] = td_data;
                tr_s[e_pos] = sof;
                tr_u[e_pos] = underflow;
                if (e_pos == FRAME - 1) tr_done = 1'b1;
            end
            if (!tr_done && pos >= 0) begin
                tr_r[pos] = pif.pix_ready;
                tr_hs[pos] = pif.pix_ready && pif.pix_valid;
            end
        end
    end

    task automatic drive(input int ps);
        int line, c;
        pif.pix_data = 16'hA555;
        pif.pix_valid = 1'b1;
        if (ps >= 0) begin
            line = ps / BL + 1;
            c = ps % BL;
            if (line == 6) pif.pix_data = 16'hFF00;
            if (line == 7) pif.pix_data = 16'h00FF;
            if (line == 8) begin
                pif.pix_data = 16'h1234;
                if (c == 32 || c == 34 || c == 36) pif.pix_valid = 1'b0;
            end
        end
    endtask

    initial begin
        drive(-1);
        forever begin
            @(posedge clk);
            #2;
            drive(pos);
        end
    end

    task automatic wait_pos(input int target, input int bound, input string nm);
        for (int i = 0; i < bound && pos != target; i++) @(negedge clk);
        chk(nm, pos, target);
    endtask

    logic [7:0] l1 [8];
    logic [7:0] sv4 [4];
    int         n;

    initial begin
        l1 = '{8'hFF, 8'h00, 8'h00, 8'hF1, 8'h80, 8'h10, 8'h80, 8'h10};
        sv4 = '{8'hFF, 8'h00, 8'h00, 8'h80};
        #1 areset = 1'b1;
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_td_data", {24'd0, td_data}, 32'h10);
        chk("rst_td_h", {31'd0, td_h}, 32'd1);
        chk("rst_td_v", {31'd0, td_v}, 32'd1);
        chk("rst_td_field", {31'd0, td_field}, 32'd1);
        chk("rst_sof", {31'd0, sof}, 32'd0);
        chk("rst_underflow", {31'd0, underflow}, 32'd0);
        chk("rst_pix_ready", {31'd0, pif.pix_ready}, 32'd0);
        @(posedge clk); #2 areset = 1'b0;
        repeat (3) @(posedge clk);
        #2 enable = 1'b1;

        for (int i = 0; i < 3 * FRAME && !tr_done; i++) @(negedge clk);
        chk("frame1_done", {31'd0, tr_done}, 32'd1);

        for (int i = 0; i < 8; i++) chk("line1_byte", {24'd0, tr_d[i]}, {24'd0, l1[i]});
        chk("sof_first", {31'd0, tr_s[0]}, 32'd1);
        n = 0;
        for (int i = 0; i < FRAME; i++) n += tr_s[i];
        chk("sof_count", n, 1);

        for (int i = 0; i < 4; i++)
            chk("line4_sav", {24'd0, tr_d[p(4, SAVP + i)]}, {24'd0, sv4[i]});
        for (int c = ACTP; c < BL; c++)
            chk("line4_act", {24'd0, tr_d[p(4, c)]}, (c % 2) ? 32'hA5 : 32'h55);
        n = 0;
        for (int c = 0; c < BL; c++) n += tr_hs[p(4, c)];
        chk("line4_handshakes", n, ACT / 2);
        chk("line5_eav", {24'd0, tr_d[p(5, 3)]}, 32'h9D);

        chk("line10_eav", {24'd0, tr_d[p(10, 3)]}, 32'hB6);
        chk("line10_sav", {24'd0, tr_d[p(10, SAVP + 3)]}, 32'hAB);
        chk("line13_eav", {24'd0, tr_d[p(13, 3)]}, 32'hDA);
        chk("line13_sav", {24'd0, tr_d[p(13, SAVP + 3)]}, 32'hC7);
        n = 0;
        for (int i = p(1, 0); i < p(4, 0); i++) n += tr_r[i];
        for (int i = p(10, 0); i < p(13, 0); i++) n += tr_r[i];
        chk("ready_in_vblank", n, 0);

        chk("clip_ff00_c", {24'd0, tr_d[p(6, ACTP)]}, 32'h01);
        chk("clip_ff00_y", {24'd0, tr_d[p(6, ACTP + 1)]}, 32'hFE);
        chk("clip_00ff_c", {24'd0, tr_d[p(7, ACTP)]}, 32'hFE);
        chk("clip_00ff_y", {24'd0, tr_d[p(7, ACTP + 1)]}, 32'h01);

        for (int c = 32; c < 38; c++)
            chk("under_fill", {24'd0, tr_d[p(8, c)]}, (c % 2) ? 32'h10 : 32'h80);
        chk("under_resume_c", {24'd0, tr_d[p(8, 38)]}, 32'h34);
        chk("under_resume_y", {24'd0, tr_d[p(8, 39)]}, 32'h12);
        n = 0;
        for (int i = 0; i < FRAME; i++) n += tr_u[i];
        chk("underflow_count", n, 3);
        n = 0;
        for (int c = 0; c < BL; c++) n += tr_hs[p(8, c)];
        chk("line8_handshakes", n, 7);
        chk("line9_eav_timing", {24'd0, tr_d[p(9, 0)]}, 32'hFF);

        wait_pos(p(2, 0), FRAME + 10, "wait_frame2");
        @(posedge clk); #2 enable = 1'b0;
        wait_pos(-1, 2 * FRAME, "wait_idle");
        repeat (5) @(negedge clk);
        chk("idle_td_data", {24'd0, td_data}, 32'h10);
        chk("idle_pix_ready", {31'd0, pif.pix_ready}, 32'd0);

        @(posedge clk); #2 enable = 1'b1;
        wait_pos(p(5, 30), 2 * FRAME, "wait_line5");
        @(posedge clk); #2 areset = 1'b1;
        #1;
        chk("arst_td_data", {24'd0, td_data}, 32'h10);
        chk("arst_td_h", {31'd0, td_h}, 32'd1);
        chk("arst_td_v", {31'd0, td_v}, 32'd1);
        chk("arst_pix_ready", {31'd0, pif.pix_ready}, 32'd0);
        @(posedge clk); #2 areset = 1'b0;
        for (int i = 0; i < 10 && e_pos != 0; i++) @(negedge clk);
        chk("restart_pos", e_pos, 0);
        chk("restart_td_data", {24'd0, td_data}, 32'hFF);
        chk("restart_sof", {31'd0, sof}, 32'd1);
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
